imem_loader: RTL and testbench

Byte-serial program loader and instruction store sitting directly upstream of the processor core. Receives a framed program image over a valid/ready byte stream and writes it into a 512 x 32 instruction memory. Holds the core in reset while loading. Once the image is verified, serves combinational instruction reads on `insMemAddr` and drives `insMemDataIn`/`insMemEn`.

---
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-serial program loader and 2^ADDR_W x 32 instruction store.
// A framed image (count lo, count hi, 4*N little-endian data bytes, checksum)
// is written into memory. The core is held in reset until the image verifies.
// The core then reads the image combinationally through insMemAddr.
module imem_loader #(
  parameter int ADDR_W = 9
) (
  input  logic              wb_clk_i,
  input  logic              reset,
  input  logic              load_start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] insMemAddr,
  output logic [31:0]       insMemDataIn,
  output logic              insMemEn,
  output logic              cpu_reset,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [31:0]     NOP       = 32'h0000_0013;
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CHK,
    S_RUN,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [1:0]        byte_idx;
  logic [7:0]        sum;
  logic [23:0]       word_asm;
  logic [31:0]       mem [2**ADDR_W];

  logic              accept;
  logic [ADDR_W:0]   hdr_count;
  logic              count_bad;
  logic              word_done;
  logic              last_word;

  // Only the low bits of the high count byte matter; the rest are ignored.
  assign accept    = rx_valid & rx_ready;
  assign hdr_count = {rx_data[ADDR_W-8:0], word_count[7:0]};
  assign count_bad = (hdr_count == '0) || (hdr_count > MAX_WORDS);
  assign word_done = (byte_idx == 2'd3);
  assign last_word = word_done && ({1'b0, wr_ptr} == (word_count - ONE));

  // State register.
  always_ff @(posedge wb_clk_i or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore outputs; load_start is ignored while a frame is in flight.
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    insMemEn  = 1'b0;
    cpu_reset = 1'b1;
    load_err  = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_start) state_nxt = S_HDR0;
      end
      S_HDR0: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = S_HDR1;
      end
      S_HDR1: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = count_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && last_word) state_nxt = S_CHK;
      end
      S_CHK: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = (rx_data == sum) ? S_RUN : S_ERR;
      end
      S_RUN: begin
        insMemEn  = 1'b1;
        cpu_reset = 1'b0;
        if (load_start) state_nxt = S_HDR0;
      end
      S_ERR: begin
        load_err = 1'b1;
        if (load_start) state_nxt = S_HDR0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Header capture, word assembly lanes, write pointer and running checksum.
  always_ff @(posedge wb_clk_i or negedge reset) begin
    if (!reset) begin
      word_count <= '0;
      wr_ptr     <= '0;
      byte_idx   <= '0;
      sum        <= '0;
      word_asm   <= '0;
    end else if (accept) begin
      case (state)
        S_HDR0: word_count[7:0] <= rx_data;
        S_HDR1: begin
          word_count[ADDR_W:8] <= rx_data[ADDR_W-8:0];
          wr_ptr               <= '0;
          byte_idx             <= '0;
          sum                  <= '0;
        end
        S_DATA: begin
          sum      <= sum + rx_data;
          byte_idx <= byte_idx + 2'd1;
          if (word_done) begin
            wr_ptr <= wr_ptr + 1'b1;
          end else begin
            word_asm[byte_idx*8 +: 8] <= rx_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory write lands on the edge that accepts the top byte of each word; contents are never reset.
  always_ff @(posedge wb_clk_i) begin
    if (accept && (state == S_DATA) && word_done) begin
      mem[wr_ptr] <= {rx_data, word_asm};
    end
  end

  // Combinational fetch; anything outside a verified image reads as NOP.
  always_comb begin
    insMemDataIn = NOP;
    if ((state == S_RUN) && ({1'b0, insMemAddr} < word_count)) begin
      insMemDataIn = mem[insMemAddr];
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. The stimulus side queues
// expected values from a frame-level reference model; a negedge monitor pops
// and compares them against the DUT outputs.
module tb_imem_loader;

  localparam int          ADDR_W = 9;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              wb_clk_i = 1'b0;
  logic              reset = 1'b0;
  logic              load_start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic [ADDR_W-1:0] ins_mem_addr = '0;
  logic [31:0]       ins_mem_data_in;
  logic              ins_mem_en;
  logic              cpu_reset;
  logic              load_err;
  logic [ADDR_W:0]   word_count;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .wb_clk_i     (wb_clk_i),
    .reset        (reset),
    .load_start   (load_start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .insMemAddr   (ins_mem_addr),
    .insMemDataIn (ins_mem_data_in),
    .insMemEn     (ins_mem_en),
    .cpu_reset    (cpu_reset),
    .load_err     (load_err),
    .word_count   (word_count)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef enum int {K_READY, K_EN, K_CPURST, K_ERR, K_WCOUNT, K_DATA, K_ACCEPT} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] value;
    int          addr;
  } exp_t;

  exp_t        exp_q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          accepted = 0;

  // Reference model: the verified image as a list of words, or nothing.
  bit          model_valid = 1'b0;
  logic [31:0] model_words[$];
  logic [31:0] frame_words[$];

  // Count bytes the DUT takes; rx_valid/rx_ready at negedge decide the next edge.
  always @(negedge wb_clk_i) begin
    if (rx_valid && rx_ready) accepted++;
  end

  // Monitor: drain every queued expectation against the DUT outputs.
  always @(negedge wb_clk_i) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_READY:  act = {31'b0, rx_ready};
        K_EN:     act = {31'b0, ins_mem_en};
        K_CPURST: act = {31'b0, cpu_reset};
        K_ERR:    act = {31'b0, load_err};
        K_WCOUNT: act = {{(31-ADDR_W){1'b0}}, word_count};
        K_DATA:   act = ins_mem_data_in;
        default:  act = 32'(accepted);
      endcase
      compared++;
      if (act !== e.value) begin
        mismatched++;
        $display("[TB] FAIL %s (addr %0d): got %h, want %h", e.kind.name(), e.addr, act, e.value);
      end
    end
  end

  function automatic logic [31:0] model_read(input int a);
    if (model_valid && a < model_words.size()) return model_words[a];
    return NOP;
  endfunction

  task automatic check_output(input kind_t k, input logic [31:0] v);
    exp_t e;
    e.kind  = k;
    e.value = v;
    e.addr  = int'(ins_mem_addr);
    exp_q.push_back(e);
  endtask

  task automatic check_read(input int a);
    ins_mem_addr = a[ADDR_W-1:0];
    check_output(K_DATA, model_read(a));
    @(posedge wb_clk_i); #1;
  endtask

  task automatic check_settled();
    check_output(K_READY, 32'd0);
    check_output(K_EN, {31'b0, model_valid});
    check_output(K_CPURST, {31'b0, !model_valid});
    check_output(K_ERR, {31'b0, !model_valid});
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    @(posedge wb_clk_i); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waited;
    if (gap) begin
      rx_valid = 1'b0;
      @(posedge wb_clk_i); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    waited   = 0;
    while (!rx_ready && waited < 50) begin
      @(posedge wb_clk_i); #1;
      waited++;
    end
    compared++;
    if (!rx_ready) begin
      mismatched++;
      $display("[TB] FAIL byte_accept: rx_ready stayed 0 for %0d cycles, want 1 (byte %h)", waited, b);
    end else begin
      @(posedge wb_clk_i); #1;
    end
    rx_valid = 1'b0;
  endtask

  // gap_mode: 0 none, 1 idle cycle before every byte, 2 random idles.
  task automatic apply_stimulus(input int count, input logic [7:0] chk_xor, input int gap_mode);
    int         base;
    int         nbytes;
    int         sum_all;
    logic [7:0] b;
    logic [7:0] chk;
    base    = accepted;
    sum_all = 0;
    pulse_load_start();
    model_valid = 1'b0;
    send_byte(count[7:0], pick_gap(gap_mode));
    send_byte(count[15:8], pick_gap(gap_mode));
    if (count == 0 || count > 512) begin
      nbytes = 2;
    end else begin
      for (int w = 0; w < count; w++) begin
        for (int k = 0; k < 4; k++) begin
          b = frame_words[w][8*k +: 8];
          sum_all += int'(b);
          send_byte(b, pick_gap(gap_mode));
        end
      end
      check_output(K_EN, 32'd0);
      chk = 8'(sum_all % 256) ^ chk_xor;
      send_byte(chk, pick_gap(gap_mode));
      nbytes = 2 + 4*count + 1;
      if (chk_xor == 8'h00) begin
        model_valid = 1'b1;
        model_words = frame_words[0:count-1];
        check_output(K_WCOUNT, 32'(count));
      end
    end
    check_output(K_ACCEPT, 32'(base + nbytes));
    check_settled();
  endtask

  function automatic bit pick_gap(input int gap_mode);
    if (gap_mode == 1) return 1'b1;
    if (gap_mode == 2) return ($urandom_range(0, 3) == 0);
    return 1'b0;
  endfunction

  task automatic fill_random(input int n);
    frame_words.delete();
    for (int i = 0; i < n; i++) frame_words.push_back($urandom);
  endtask

  // Watchdog: any hang ends the run with a reported failure.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int n;
    int cnt;
    #1;
    check_output(K_READY, 32'd0);
    check_output(K_EN, 32'd0);
    check_output(K_CPURST, 32'd1);
    check_output(K_ERR, 32'd0);
    check_output(K_WCOUNT, 32'd0);
    check_output(K_DATA, NOP);
    repeat (2) @(posedge wb_clk_i);
    #1 reset = 1'b1;
    @(posedge wb_clk_i); #1;

    $display("[TB] directed N=2 frame");
    frame_words = '{32'h00500093, 32'h00A00113};
    apply_stimulus(2, 8'h00, 0);
    check_read(0);
    check_read(1);
    check_read(2);

    $display("[TB] wrong checksum");
    apply_stimulus(2, 8'h01, 0);
    check_read(0);
    pulse_load_start();
    check_output(K_ERR, 32'd0);
    check_output(K_READY, 32'd1);

    $display("[TB] bad header counts");
    apply_stimulus(0, 8'h00, 0);
    check_read(0);
    apply_stimulus(513, 8'h00, 0);
    check_read(1);

    $display("[TB] N=1 frame with toggling rx_valid");
    frame_words = '{32'h12345678};
    apply_stimulus(1, 8'h00, 1);
    check_read(0);
    check_read(1);

    $display("[TB] reset mid-load");
    pulse_load_start();
    model_valid = 1'b0;
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), 1'b0);
    reset = 1'b0;
    #1;
    ins_mem_addr = '0;
    check_output(K_READY, 32'd0);
    check_output(K_EN, 32'd0);
    check_output(K_CPURST, 32'd1);
    check_output(K_ERR, 32'd0);
    check_output(K_WCOUNT, 32'd0);
    check_output(K_DATA, NOP);
    @(posedge wb_clk_i); #1;
    reset = 1'b1;
    @(posedge wb_clk_i); #1;
    frame_words = '{32'hDEADBEEF};
    apply_stimulus(1, 8'h00, 0);
    check_read(0);
    check_read(1);

    $display("[TB] load_start while running");
    pulse_load_start();
    model_valid = 1'b0;
    check_output(K_EN, 32'd0);
    check_output(K_CPURST, 32'd1);
    check_read(0);
    fill_random(3);
    apply_stimulus(3, 8'h00, 2);
    check_read(2);
    check_read(3);

    $display("[TB] full-depth 512-word image");
    fill_random(512);
    apply_stimulus(512, 8'h00, 0);
    check_read(0);
    check_read(510);
    check_read(511);

    $display("[TB] randomized frames");
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(1, 8);
      fill_random(n);
      case ($urandom_range(0, 7))
        0:       apply_stimulus(0, 8'h00, 2);
        1:       apply_stimulus($urandom_range(513, 1023), 8'h00, 2);
        2:       apply_stimulus(n, 8'($urandom_range(1, 255)), 2);
        default: apply_stimulus(n, 8'h00, 2);
      endcase
      check_read(0);
      check_read(n - 1);
      check_read(n);
      cnt = $urandom_range(0, 15);
      check_read(cnt);
    end

    repeat (2) @(posedge wb_clk_i);
    #1;
    if (exp_q.size() != 0) begin
      mismatched += exp_q.size();
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
